// File: rtl/sdpram_pkg.sv
// ==== sdpram_pkg: shared types and helpers for the wide-read dual-port RAM ====
// ==== Revision 1.0                                                          ====
`default_nettype none

package sdpram_pkg;

  typedef enum logic [1:0] {
    CLEAR     = 2'd0,
    DONE_WAIT = 2'd1,
    RUN       = 2'd2
  } seq_state_t;

  // Upper bounds for the generic lane_merge arguments; callers size-cast in and out.
  localparam int MAX_ROW_BITS  = 1024;
  localparam int MAX_WORD_BITS = 256;
  localparam int MAX_STRB_BITS = MAX_WORD_BITS / 8;

  function automatic int rows_of(input int depth, input int mul);
    return depth / mul;
  endfunction

  function automatic int lane_bits_of(input int mul);
    return (mul > 1) ? $clog2(mul) : 0;
  endfunction

  // Replace the strobed bytes of one lane of a row with the matching bytes of data.
  function automatic logic [MAX_ROW_BITS-1:0] lane_merge(
    input logic [MAX_ROW_BITS-1:0]  old_row,
    input int                       lane,
    input logic [MAX_STRB_BITS-1:0] strb,
    input logic [MAX_WORD_BITS-1:0] data,
    input int                       word_bits
  );
    logic [MAX_ROW_BITS-1:0] row;
    row = old_row;
    for (int i = 0; i < MAX_STRB_BITS; i++) begin
      if ((i < word_bits / 8) && strb[i] &&
          ((lane * (word_bits / 8) + i) < MAX_ROW_BITS / 8)) begin
        row[(lane * (word_bits / 8) + i) * 8 +: 8] = data[i * 8 +: 8];
      end
    end
    return row;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sdpram_clear_seq.sv
// ==== sdpram_clear_seq: post-reset row-clear sequencer, raises init_done ====
// ==== Revision 1.0                                                       ====
`default_nettype none

module sdpram_clear_seq
  import sdpram_pkg::*;
#(
  parameter int ROWS       = 256,
  parameter int ROW_BITS   = 8,
  parameter int INIT_CLEAR = 1
) (
  input  logic                clk,
  input  logic                rst,
  output logic                clr_en,
  output logic [ROW_BITS-1:0] clr_row,
  output logic                init_done
);

  localparam seq_state_t    START    = (INIT_CLEAR != 0) ? CLEAR : DONE_WAIT;
  localparam [ROW_BITS-1:0] LAST_ROW = ROW_BITS'(ROWS - 1);

  seq_state_t          state, state_nxt;
  logic [ROW_BITS-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= START;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    clr_en    = 1'b0;
    case (state)
      CLEAR: begin
        clr_en  = 1'b1;
        cnt_nxt = cnt + 1'b1;
        if (cnt == LAST_ROW) state_nxt = RUN;
      end
      DONE_WAIT: state_nxt = RUN;
      RUN:       state_nxt = RUN;
      default:   state_nxt = START;
    endcase
  end

  assign clr_row   = cnt;
  assign init_done = (state == RUN);

endmodule

`default_nettype wire

// File: rtl/sdpram_wide_bypass.sv
// ==== sdpram_wide_bypass: narrow byte-strobed write, wide row read, clear-on-reset ====
// ==== Revision 1.0                                                                ====
`default_nettype none

module sdpram_wide_bypass
  import sdpram_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 1024,
  parameter int READ_MUL    = 4,
  parameter int LATENCY     = 1,
  parameter int WRITE_FIRST = 1,
  parameter int INIT_CLEAR  = 1
) (
  input  logic                                clk,
  input  logic                                rst,
  output logic                                init_done,
  input  logic                                wr_en,
  input  logic [$clog2(DEPTH)-1:0]            wr_addr,
  input  logic [DATA_WIDTH/8-1:0]             wr_strb,
  input  logic [DATA_WIDTH-1:0]               wr_data,
  input  logic                                rd_en,
  input  logic [$clog2(DEPTH/READ_MUL)-1:0]   rd_addr,
  output logic [READ_MUL*DATA_WIDTH-1:0]      rd_data,
  output logic                                rd_valid
);

  localparam int ROWS      = rows_of(DEPTH, READ_MUL);
  localparam int LANE_BITS = lane_bits_of(READ_MUL);
  localparam int LANE_W    = (LANE_BITS > 0) ? LANE_BITS : 1;
  localparam int ROW_W     = READ_MUL * DATA_WIDTH;
  localparam int NBYTES    = ROW_W / 8;
  localparam int WA_W      = $clog2(DEPTH);
  localparam int RA_W      = $clog2(ROWS);

  logic [NBYTES-1:0][7:0] mem [ROWS];

  logic                   clr_en;
  logic [RA_W-1:0]        clr_row;
  logic [RA_W-1:0]        wr_row;
  logic [LANE_W-1:0]      wr_lane;
  logic                   wr_fire, rd_fire, wr_hits;
  logic [ROW_W-1:0]       wr_row_data, rd_raw, rd_fwd, rd_word;
  logic [NBYTES-1:0]      wr_be, mem_we;
  logic [RA_W-1:0]        mem_row;
  logic [NBYTES-1:0][7:0] mem_data;

  sdpram_clear_seq #(
    .ROWS       (ROWS),
    .ROW_BITS   (RA_W),
    .INIT_CLEAR (INIT_CLEAR)
  ) u_seq (
    .clk       (clk),
    .rst       (rst),
    .clr_en    (clr_en),
    .clr_row   (clr_row),
    .init_done (init_done)
  );

  generate
    if (READ_MUL == 1) begin : g_single_lane
      assign wr_row  = wr_addr;
      assign wr_lane = '0;
    end else begin : g_multi_lane
      assign wr_row  = wr_addr[WA_W-1:LANE_BITS];
      assign wr_lane = wr_addr[LANE_BITS-1:0];
    end
  endgenerate

  assign wr_fire     = init_done & wr_en;
  assign rd_fire     = init_done & rd_en;
  assign wr_be       = NBYTES'(wr_strb) << (int'(wr_lane) * (DATA_WIDTH / 8));
  assign wr_row_data = ROW_W'(lane_merge('0, int'(wr_lane), MAX_STRB_BITS'(wr_strb),
                                         MAX_WORD_BITS'(wr_data), DATA_WIDTH));

  // The clear sequencer owns the write port until it reaches RUN.
  always_comb begin
    mem_we   = '0;
    mem_row  = wr_row;
    mem_data = wr_row_data;
    if (clr_en) begin
      mem_we   = '1;
      mem_row  = clr_row;
      mem_data = '0;
    end else if (wr_fire) begin
      mem_we = wr_be;
    end
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < NBYTES; b++) begin
      if (mem_we[b]) mem[mem_row][b] <= mem_data[b];
    end
  end

  assign rd_raw  = mem[rd_addr];
  assign wr_hits = wr_fire && (wr_row == rd_addr);
  assign rd_fwd  = ROW_W'(lane_merge(MAX_ROW_BITS'(rd_raw), int'(wr_lane),
                                     MAX_STRB_BITS'(wr_strb), MAX_WORD_BITS'(wr_data),
                                     DATA_WIDTH));
  assign rd_word = ((WRITE_FIRST != 0) && wr_hits) ? rd_fwd : rd_raw;

  logic             s1_valid;
  logic [ROW_W-1:0] s1_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= rd_fire;
      if (rd_fire) s1_data <= rd_word;
    end
  end

  generate
    if (LATENCY == 2) begin : g_lat2
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rd_valid <= 1'b0;
          rd_data  <= '0;
        end else begin
          rd_valid <= s1_valid;
          if (s1_valid) rd_data <= s1_data;
        end
      end
    end else begin : g_lat1
      assign rd_valid = s1_valid;
      assign rd_data  = s1_data;
    end
  endgenerate

endmodule

`default_nettype wire
